// File: rtl/wave_sequencer_if.sv
// ----------------------------------------------------------------------------
// wave_sequencer_if
//  Sample delivery channel between wave_sequencer and the sample consumer
//  (DAC/PWM stage). Valid/ready handshake: a sample is transferred on every
//  clock edge where sample_valid and sample_ready are both high.
//
//  Signals
//    sample        DATA_W  sample value, stable while sample_valid is high
//    sample_valid  1       sample available
//    sample_ready  1       consumer accepts the sample
//
//  Modports
//    master  producer side (wave_sequencer)
//    slave   consumer side
// ----------------------------------------------------------------------------
interface wave_sequencer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] sample;
  logic              sample_valid;
  logic              sample_ready;

  modport master (
    output sample,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/wave_sequencer.sv
// ----------------------------------------------------------------------------
// wave_sequencer
//  Address generator for a 2^ADDR_W x DATA_W waveform ROM with a one-cycle
//  registered read. A phase accumulator advances by a programmable step per
//  delivered sample; the upper ADDR_W bits of the accumulator address the ROM.
//  Each sample is fetched, captured and then held on a valid/ready channel
//  until the consumer takes it. Playback is either one-shot (ends when the
//  accumulator overflows, with a one-cycle done pulse) or looped (wraps
//  forever until stop).
//
//  Ports
//    clk       in   system clock, all logic on posedge
//    reset     in   synchronous active-high reset
//    start     in   start pulse, honoured only when idle
//    stop      in   abort playback (level, checked every cycle)
//    loop      in   1 = wrap forever, 0 = one-shot; captured on start
//    step      in   ACC_W phase increment per sample; captured on start
//    rom_addr  out  ROM address, upper ADDR_W bits of the accumulator
//    rom_data  in   ROM read data, valid one cycle after rom_addr
//    smp       if   master side of the sample valid/ready channel
//    busy      out  high whenever playback is in progress
//    done      out  one-cycle pulse when a one-shot playback completes
//    gain      in   8-bit amplitude gain (only with AMP_SCALE_EN)
//
//  Build option
//    AMP_SCALE_EN  when defined, adds the gain port and captures
//                  (rom_data * (gain+1)) >> 8 instead of rom_data;
//                  gain = 8'hFF is unity.
// ----------------------------------------------------------------------------
module wave_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
  input  logic [ACC_W-1:0]   step,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  wave_sequencer_if.master   smp,
  output logic               busy,
  output logic               done
`ifdef AMP_SCALE_EN
  ,
  input  logic [7:0]         gain
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                loop_q, loop_d;
  logic [ACC_W-1:0]    step_q, step_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic [ACC_W:0]      sum;

`ifdef AMP_SCALE_EN
  localparam int PROD_W = DATA_W + 9;

  // (d * (g + 1)) >> 8, computed as d*g + d to keep the multiplier at 8 bits.
  // The result never exceeds d, so truncation to DATA_W loses nothing.
  function automatic logic [DATA_W-1:0] scale_sample(input logic [DATA_W-1:0] d,
                                                     input logic [7:0]        g);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(d) * PROD_W'(g) + PROD_W'(d);
    return DATA_W'(prod >> 8);
  endfunction
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    loop_d   = loop_q;
    step_d   = step_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    // Extra top bit is the carry that marks the end of a one-shot pass.
    sum      = {1'b0, acc_q} + {1'b0, step_q};

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          acc_d   = '0;
          loop_d  = loop;
          step_d  = step;
          state_d = S_FETCH;
        end
      end

      // rom_addr already shows acc_q; the ROM registers its data at this edge.
      S_FETCH: begin
        if (stop) begin
          acc_d   = '0;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (stop) begin
          acc_d   = '0;
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else begin
`ifdef AMP_SCALE_EN
          sample_d = scale_sample(rom_data, gain);
`else
          sample_d = rom_data;
`endif
          valid_d  = 1'b1;
          state_d  = S_HOLD;
        end
      end

      // Everything stays frozen until the consumer takes the sample. A stop
      // arriving with the handshake aborts without advancing the phase.
      S_HOLD: begin
        if (stop) begin
          acc_d   = '0;
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else if (smp.sample_ready) begin
          valid_d = 1'b0;
          if (sum[ACC_W] && !loop_q) begin
            done_d  = 1'b1;
            acc_d   = '0;
            state_d = S_IDLE;
          end else begin
            acc_d   = sum[ACC_W-1:0];
            state_d = S_FETCH;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      loop_q   <= 1'b0;
      step_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      loop_q   <= loop_d;
      step_q   <= step_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign rom_addr         = acc_q[ACC_W-1 -: ADDR_W];
  assign smp.sample       = sample_q;
  assign smp.sample_valid = valid_q;
  assign busy             = (state_q != S_IDLE);
  assign done             = done_q;

endmodule

// File: tb/tb_wave_sequencer.sv
// ----------------------------------------------------------------------------
// tb_wave_sequencer
//  Self-checking bench for wave_sequencer with a 256x8 registered-read ROM
//  model. Table-driven playback vectors, hand-written corner sequences and
//  randomized playbacks checked against a closed-form reference model:
//  sample i reads rom[((i*step) mod 2^16) >> 8]; a one-shot delivers
//  ceil(2^16/step) samples and then pulses done.
// ----------------------------------------------------------------------------
module tb_wave_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic        loop;
  logic [15:0] step;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data;
  logic        busy;
  logic        done;
`ifdef AMP_SCALE_EN
  logic [7:0]  gain;
`endif

  logic [7:0]  rom [256];

  wave_sequencer_if #(.DATA_W(8)) sif ();

  wave_sequencer #(
    .ADDR_W(8),
    .DATA_W(8),
    .ACC_W (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .loop    (loop),
    .step    (step),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .smp     (sif.master),
    .busy    (busy),
    .done    (done)
`ifdef AMP_SCALE_EN
    ,
    .gain    (gain)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct {
    logic [15:0] st;
    logic        lp;
    int          stall;      // percent of cycles with ready low
    int          n;          // samples to collect
    logic [31:0] first;      // first four expected samples, s0 in [7:0]
    logic        chk_first;
    logic        exp_done;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  int          dones = 0;
  int          both_hi = 0;
  logic [7:0]  got_q [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] model_sample(input int i, input logic [15:0] st);
    longint a;
    a = (longint'(i) * longint'(st)) % 65536;
    return rom[int'(a / 256)];
  endfunction

  function automatic int model_count(input logic [15:0] st);
    return (65536 + int'(st) - 1) / int'(st);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at #1 after an edge with the DUT idle; loop/step are scrambled
  // afterwards since the DUT must ignore them while busy.
  task automatic start_play(input logic [15:0] st, input logic lp);
    sif.sample_ready = 1'b0;
    step  = st;
    loop  = lp;
    start = 1'b1;
    tick();
    start = 1'b0;
    step  = 16'($urandom);
    loop  = 1'($urandom);
  endtask

  task automatic collect(input int nsamp, input int stall_pct);
    int   cyc;
    logic r;
    cyc = 0;
    got_q.delete();
    while (got_q.size() < nsamp && cyc < 5000) begin
      r = ($urandom_range(99) >= stall_pct);
      sif.sample_ready = r;
      if (done) dones++;
      if (done && sif.sample_valid) both_hi++;
      if (sif.sample_valid && r) got_q.push_back(sif.sample);
      tick();
      cyc++;
    end
    sif.sample_ready = 1'b0;
    if (cyc >= 5000) check("collect_timeout", got_q.size(), nsamp);
  endtask

  task automatic stop_and_check(input string tag);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check({tag, "_stop_busy"},  busy, 0);
    check({tag, "_stop_valid"}, sif.sample_valid, 0);
    check({tag, "_stop_done"},  done, 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    dones = 0;
    start_play(v.st, v.lp);
    collect(v.n, v.stall);
    for (int k = 0; k < v.n; k++)
      check($sformatf("%s_s%0d", tag, k), got_q[k], model_sample(k, v.st));
    if (v.chk_first)
      for (int k = 0; k < 4 && k < v.n; k++)
        check($sformatf("%s_first%0d", tag, k), got_q[k], v.first[8*k +: 8]);
    check({tag, "_early_done"}, dones, 0);
    if (v.exp_done) begin
      check({tag, "_done_pulse"}, done, 1);
      check({tag, "_done_busy"},  busy, 0);
      check({tag, "_done_valid"}, sif.sample_valid, 0);
      tick();
      check({tag, "_done_1cyc"},  done, 0);
      check({tag, "_idle_busy"},  busy, 0);
    end else begin
      check({tag, "_running"}, busy, 1);
      stop_and_check(tag);
    end
  endtask

  vec_t vecs [7];

  initial begin
    int    n;
    logic  same_s, same_a, same_v;
    logic [7:0] s0, a0;
    vec_t  v;

    vecs[0] = '{16'h0100, 1'b0,  0, 256, 32'h03020100, 1'b1, 1'b1};
    vecs[1] = '{16'h8000, 1'b1,  0,   8, 32'h80008000, 1'b1, 1'b0};
    vecs[2] = '{16'h4000, 1'b0, 30,   4, 32'hC0804000, 1'b1, 1'b1};
    vecs[3] = '{16'h0000, 1'b0,  0,   6, 32'h00000000, 1'b1, 1'b0};
    vecs[4] = '{16'hFFFF, 1'b0, 50,   2, 32'h0000FF00, 1'b1, 1'b1};
    vecs[5] = '{16'h0180, 1'b1, 20,  10, 32'h04030100, 1'b1, 1'b0};
    vecs[6] = '{16'hC000, 1'b1,  0,   6, 32'h4080C000, 1'b1, 1'b0};

    for (int i = 0; i < 256; i++) rom[i] = 8'(i);
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; step = '0;
    sif.sample_ready = 1'b0;
`ifdef AMP_SCALE_EN
    gain = 8'hFF;
`endif
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_addr",  rom_addr, 0);
    check("rst_sample", sif.sample, 0);
    check("rst_valid", sif.sample_valid, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Latency from start, then a 10-cycle stall in HOLD
    step = 16'h0100; loop = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!sif.sample_valid && n < 20) begin tick(); n++; end
    check("start_latency", n, 3);
    s0 = sif.sample; a0 = rom_addr;
    same_s = 1'b1; same_a = 1'b1; same_v = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sif.sample != s0)    same_s = 1'b0;
      if (rom_addr != a0)      same_a = 1'b0;
      if (!sif.sample_valid)   same_v = 1'b0;
    end
    check("stall_sample", {same_s, s0}, {1'b1, 8'h00});
    check("stall_addr",   same_a, 1);
    check("stall_valid",  same_v, 1);
    sif.sample_ready = 1'b1;
    tick();
    sif.sample_ready = 1'b0;
    n = 1;
    while (!sif.sample_valid && n < 20) begin tick(); n++; end
    check("after_stall_latency", n, 3);
    check("after_stall_sample", sif.sample, 8'h01);

    // Stop together with a handshake in HOLD
    sif.sample_ready = 1'b1;
    stop_and_check("hold");
    sif.sample_ready = 1'b0;
    tick();
    check("hold_stop_stays_idle", busy, 0);

    // start and stop in the same idle cycle
    start = 1'b1; stop = 1'b1; step = 16'h0100;
    tick();
    start = 1'b0; stop = 1'b0;
    check("start_stop_busy", busy, 0);
    tick();
    check("start_stop_busy2", busy, 0);

    // Reset in WAIT, then replay from rom[0]
    start_play(16'h4000, 1'b1);
    collect(2, 0);
    check("pre_rst_s1", got_q[1], 8'h40);
    tick();
    check("wait_addr", rom_addr, 8'h80);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_addr",   rom_addr, 0);
    check("mid_rst_sample", sif.sample, 0);
    check("mid_rst_valid",  sif.sample_valid, 0);
    check("mid_rst_busy",   busy, 0);
    check("mid_rst_done",   done, 0);
    start_play(16'h0100, 1'b0);
    collect(1, 0);
    check("replay_s0", got_q[0], rom[0]);
    stop_and_check("replay");

`ifdef AMP_SCALE_EN
    rom[0] = 8'h80; rom[1] = 8'hC3;
    gain = 8'h7F;
    start_play(16'h0100, 1'b1);
    collect(1, 0);
    check("gain_7f", got_q[0], 8'h40);
    gain = 8'hFF;
    collect(1, 0);
    check("gain_ff", got_q[0], 8'hC3);
    stop_and_check("gain");
    gain = 8'hFF;
`endif

    // Randomized playbacks with random ROM contents
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
      v.st        = 16'($urandom_range(65535, 1024));
      v.lp        = 1'($urandom_range(1));
      v.stall     = $urandom_range(60);
      v.first     = '0;
      v.chk_first = 1'b0;
      if (v.lp) begin
        v.n = 12;
        v.exp_done = 1'b0;
      end else begin
        v.n = model_count(v.st);
        v.exp_done = 1'b1;
      end
      run_vec(v, $sformatf("rnd%0d", r));
    end

    check("done_with_valid", both_hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
